// File: rtl/cache_pmem_arbiter_if.sv
// Bundle of icache, dcache and physical-memory line ports seen by the arbiter.
// The slave modport is the arbiter's view; master is the caches/memory side.
interface cache_pmem_arbiter_if #(
    parameter int s_line = 256,
    parameter int s_addr = 32
);
    logic [s_addr-1:0] i_pmem_address;
    logic              i_pmem_read;
    logic              i_pmem_resp;
    logic [s_line-1:0] i_pmem_rdata;

    logic [s_addr-1:0] d_pmem_address;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [s_line-1:0] d_pmem_wdata;
    logic              d_pmem_resp;
    logic [s_line-1:0] d_pmem_rdata;

    logic [s_addr-1:0] pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [s_line-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [s_line-1:0] pmem_rdata;

    modport slave (
        input  i_pmem_address, i_pmem_read,
        input  d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
        input  pmem_resp, pmem_rdata,
        output i_pmem_resp, i_pmem_rdata,
        output d_pmem_resp, d_pmem_rdata,
        output pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport master (
        output i_pmem_address, i_pmem_read,
        output d_pmem_address, d_pmem_read, d_pmem_write, d_pmem_wdata,
        output pmem_resp, pmem_rdata,
        input  i_pmem_resp, i_pmem_rdata,
        input  d_pmem_resp, d_pmem_rdata,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/cache_pmem_arbiter.sv
// Shares one physical-memory line port between icache and dcache, one whole
// transaction at a time, round-robin on ties, with registered pmem strobes.
module cache_pmem_arbiter #(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input logic                 clk,
    input logic                 rst,
    cache_pmem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    logic [1:0]        state;
    logic              last_grant_d;
    logic              pmem_read_q;
    logic              pmem_write_q;
    logic [s_addr-1:0] address_q;
    logic [s_line-1:0] wdata_q;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;

    // On a tie the side that did not win last time goes first.
    assign i_req   = bus.i_pmem_read;
    assign d_req   = bus.d_pmem_read | bus.d_pmem_write;
    assign grant_i = i_req & (~d_req | last_grant_d);
    assign grant_d = d_req & ~grant_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b1;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            address_q    <= '0;
            wdata_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state        <= SERVE_I;
                        last_grant_d <= 1'b0;
                        address_q    <= bus.i_pmem_address;
                        pmem_read_q  <= 1'b1;
                        pmem_write_q <= 1'b0;
                    end else if (grant_d) begin
                        state        <= SERVE_D;
                        last_grant_d <= 1'b1;
                        address_q    <= bus.d_pmem_address;
                        wdata_q      <= bus.d_pmem_wdata;
                        pmem_read_q  <= ~bus.d_pmem_write;
                        pmem_write_q <= bus.d_pmem_write;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.pmem_resp) begin
                        state        <= IDLE;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = address_q;
    assign bus.pmem_wdata   = wdata_q;

    // A response arriving while reset is held belongs to a dropped transaction.
    assign bus.i_pmem_resp  = ~rst & (state == SERVE_I) & bus.pmem_resp;
    assign bus.d_pmem_resp  = ~rst & (state == SERVE_D) & bus.pmem_resp;
    assign bus.i_pmem_rdata = bus.pmem_rdata;
    assign bus.d_pmem_rdata = bus.pmem_rdata;
endmodule

// File: doc/cache_pmem_arbiter.md
Name: cache_pmem_arbiter

Overview:
- Shares one physical-memory port (256-bit line, 32-bit address) between an instruction cache (read-only) and a data cache (read/write-back).
- Sits between the two cache instances and the physical-memory / cacheline-adaptor interface.
- Grants one whole line transaction at a time and routes the response to the requester that owns it.
- Ties between the two caches are broken round-robin.

Parameters:
- s_line, 256, cacheline width in bits (all wdata/rdata buses).
- s_addr, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_pmem_address  in  s_addr  icache line address
- i_pmem_read  in  1  icache line read request (level, held until resp)
- i_pmem_resp  out  1  icache transaction done (1-cycle pulse)
- i_pmem_rdata  out  s_line  icache read data
- d_pmem_address  in  s_addr  dcache line address
- d_pmem_read  in  1  dcache line read request (level)
- d_pmem_write  in  1  dcache writeback request (level)
- d_pmem_wdata  in  s_line  dcache writeback data
- d_pmem_resp  out  1  dcache transaction done (1-cycle pulse)
- d_pmem_rdata  out  s_line  dcache read data
- pmem_address  out  s_addr  physical-memory address
- pmem_read  out  1  physical-memory read strobe
- pmem_write  out  1  physical-memory write strobe
- pmem_wdata  out  s_line  physical-memory write data
- pmem_resp  in  1  physical-memory done (1-cycle pulse)
- pmem_rdata  in  s_line  physical-memory read data

Behaviour:
- States: IDLE, SERVE_I, SERVE_D.
- Reset values: state=IDLE, last_grant=D; pmem_read, pmem_write, i_pmem_resp, d_pmem_resp all 0; pmem_address=0; pmem_wdata=0.
- d_req = d_pmem_read | d_pmem_write. i_req = i_pmem_read.
- IDLE, arbitration:
  - Only one request present: grant it.
  - Both present: grant the side not equal to last_grant.
  - On grant, at the clock edge: latch the requester's address into pmem_address. For D, also latch d_pmem_wdata into pmem_wdata and latch op = write if d_pmem_write else read. Set last_grant. Move to SERVE_I or SERVE_D.
  - d_pmem_read and d_pmem_write both high: write wins.
- SERVE_x:
  - pmem_read/pmem_write are registered and held asserted while in the state.
  - Latched address/wdata stay stable regardless of input changes.
  - Latency: request visible in IDLE at cycle N gives pmem strobe high at cycle N+1.
- On pmem_resp in SERVE_x:
  - Pulse x_pmem_resp combinationally in the same cycle; the other resp stays 0.
  - Return to IDLE at the edge; pmem strobes are 0 in IDLE.
  - This guarantees at least one idle cycle between consecutive pmem transactions.
- i_pmem_rdata and d_pmem_rdata are driven directly from pmem_rdata at all times. Data is valid only in the resp cycle.
- Requester drops its request mid-transaction: the transaction still completes and resp still pulses. The requester must not rely on cancellation.
- pmem_resp while IDLE: ignored. No resp is forwarded and the state does not change.
- Reset mid-transaction: IDLE and strobes 0 on the next edge. Any in-flight pmem response is dropped.
- No combinational path from request inputs to pmem strobes or address.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no requests -> pmem_read=pmem_write=0, pmem_address=0, both resps 0.
- Lone icache read: i_pmem_read=1, addr=0x0000_0060 -> next cycle pmem_read=1, pmem_address=0x60. pmem_resp after 5 cycles with rdata=0xA5..A5 -> i_pmem_resp=1 that cycle with i_pmem_rdata=0xA5..A5, d_pmem_resp=0, strobe low next cycle.
- Dcache writeback: d_pmem_write=1, addr=0x8000_0100, wdata=0x1234..; change wdata the cycle after grant -> pmem_write=1, pmem_wdata still 0x1234.., d_pmem_resp on pmem_resp.
- Simultaneous requests from reset: i and d reads same cycle -> icache granted first (last_grant=D at reset). After its resp, one idle cycle, then dcache granted. Repeat with both held -> strict I/D alternation.
- Back-to-back dcache: writeback resp, then d_pmem_read next cycle at new address -> read issued after one IDLE cycle with new address; an icache request arriving during the writeback is served before the dcache read (round-robin).
- Corner cases: spurious pmem_resp in IDLE -> no resp out. rst asserted during SERVE_D -> strobes 0 next cycle, and a later pmem_resp is ignored.
